// File: rtl/main_memory_responder_pkg.sv
// Shared cache/memory interface types, responder state encoding and block-index helper.
package cache_parameters;

  localparam int unsigned WORD_WIDTH   = 32;
  localparam int unsigned BLOCK_SIZE   = 4;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE) + $clog2(WORD_WIDTH / 8);

  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    block_t                data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESPOND
  } resp_state_t;

  // Block number of a byte address; callers keep the low index bits, so upper bits alias.
  function automatic logic [ADDR_WIDTH-1:0] block_number(input logic [ADDR_WIDTH-1:0] addr);
    return addr >> OFFSET_WIDTH;
  endfunction

endpackage

// File: rtl/main_memory_responder_array.sv
// Single-port block storage: synchronous write, registered read that returns zero when not reading.
module mem_block_array
  import cache_parameters::*;
#(
  parameter int unsigned MEM_BLOCKS = 256,
  localparam int unsigned IDX_W     = $clog2(MEM_BLOCKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  block_t           wdata_i,
  output block_t           rdata_o
);

  block_t mem_q [MEM_BLOCKS];
  block_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register doubles as the response data bus, so it is cleared on every non-read cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Block-granular backing memory answering cache requests after a fixed read/write latency.
module main_memory_responder
  import cache_parameters::*;
#(
  parameter int unsigned MEM_BLOCKS    = 256,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  mem_req,
  output memory_response_t mem_res,
  output logic             init_done
);

  localparam int unsigned BLK_IDX_W = $clog2(MEM_BLOCKS);
  localparam int unsigned LAT_MAX   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned LAT_W     = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  resp_state_t          state_q, state_d;
  logic [BLK_IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic                 rw_q, rw_d;
  logic [BLK_IDX_W-1:0] idx_q, idx_d;
  block_t               wdata_q, wdata_d;
  logic                 ack_q, ack_d;
  logic                 init_done_q, init_done_d;

  logic                 arr_we;
  logic                 arr_re;
  logic [BLK_IDX_W-1:0] arr_addr;
  block_t               arr_wdata;
  block_t               arr_rdata;
  logic [BLK_IDX_W-1:0] req_idx;

  assign req_idx = BLK_IDX_W'(block_number(mem_req.addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      rw_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      rw_q        <= rw_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    rw_d        = rw_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    init_done_d = init_done_q;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_addr    = idx_q;
    arr_wdata   = wdata_q;

    unique case (state_q)
      INIT: begin
        arr_we     = 1'b1;
        arr_addr   = init_cnt_q;
        arr_wdata  = '0;
        init_cnt_d = init_cnt_q + BLK_IDX_W'(1);
        if (init_cnt_q == BLK_IDX_W'(MEM_BLOCKS - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (mem_req.cs) begin
          rw_d      = mem_req.rw;
          idx_d     = req_idx;
          wdata_d   = mem_req.data;
          lat_cnt_d = mem_req.rw ? LAT_W'(WRITE_LATENCY - 1) : LAT_W'(READ_LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A dropped cs abandons the request before anything is committed.
        if (!mem_req.cs) begin
          state_d = IDLE;
        end else if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end else begin
          state_d = RESPOND;
          ack_d   = 1'b1;
          arr_we  = rw_q;
          arr_re  = !rw_q;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  mem_block_array #(
    .MEM_BLOCKS(MEM_BLOCKS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (arr_we),
    .re_i   (arr_re),
    .addr_i (arr_addr),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  assign mem_res   = '{ack: ack_q, data: arr_rdata};
  assign init_done = init_done_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized bench for main_memory_responder against a transaction-level memory model.
module tb_main_memory_responder;
  import cache_parameters::*;

  localparam int RL  = 4;
  localparam int WL  = 4;
  localparam int NBL = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  memory_request_t  req = '0;
  memory_response_t mem_res;
  logic             init_done;

  int n_checks = 0;
  int n_errors = 0;

  main_memory_responder #(
    .MEM_BLOCKS   (NBL),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (req),
    .mem_res  (mem_res),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  block_t m_mem [NBL];
  int     m_init_cycles = 0;
  bit     m_init_done   = 0;
  bit     m_busy        = 0;
  int     m_age         = 0;
  bit     m_rw          = 0;
  int     m_idx         = 0;
  block_t m_data        = '0;
  bit     exp_ack       = 0;
  block_t exp_data      = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_init_cycles = 0;
        m_init_done   = 0;
        m_busy        = 0;
        exp_ack       = 0;
        exp_data      = '0;
        for (int i = 0; i < NBL; i++) m_mem[i] = '0;
      end else if (!m_init_done) begin
        m_init_cycles++;
        if (m_init_cycles == NBL) m_init_done = 1;
      end else if (exp_ack) begin
        exp_ack  = 0;
        exp_data = '0;
      end else if (!m_busy) begin
        if (req.cs) begin
          m_busy = 1;
          m_age  = 0;
          m_rw   = req.rw;
          m_idx  = int'((req.addr >> OFFSET_WIDTH) % NBL);
          m_data = req.data;
        end
      end else if (!req.cs) begin
        m_busy = 0;
      end else begin
        m_age++;
        if (m_age == (m_rw ? WL : RL)) begin
          m_busy  = 0;
          exp_ack = 1;
          if (m_rw) m_mem[m_idx] = m_data;
          else      exp_data = m_mem[m_idx];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || m_init_cycles > 0 || m_init_done) begin
        check("ack", mem_res.ack, exp_ack);
        check("data", mem_res.data, exp_data);
        check("init_done", init_done, m_init_done);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic block_t rand_block();
    block_t b;
    for (int w = 0; w < BLOCK_SIZE; w++) b[w] = $urandom;
    return b;
  endfunction

  function automatic logic [31:0] blk_addr(input int blk, input int off);
    return (32'(blk) << OFFSET_WIDTH) | 32'(off);
  endfunction

  task automatic do_reset(output int n);
    req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", mem_res.ack, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    rst = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_req(input logic rw, input logic [31:0] addr, input block_t data,
                        input bit scramble, output int lat, output block_t rdata);
    @(posedge clk);
    #1;
    req.cs = 1'b1; req.rw = rw; req.addr = addr; req.data = data;
    lat = -1;
    rdata = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (scramble && n == 1) begin
        req.addr = $urandom;
        req.data = rand_block();
        req.rw   = ~rw;
      end
      if (mem_res.ack === 1'b1) begin
        lat = n;
        rdata = mem_res.data;
        break;
      end
    end
    req.cs = 1'b0;
  endtask

  task automatic do_abort(input logic rw, input logic [31:0] addr, input block_t data, input int k);
    @(posedge clk);
    #1;
    req.cs = 1'b1; req.rw = rw; req.addr = addr; req.data = data;
    repeat (k + 1) begin
      @(posedge clk);
      #1;
    end
    req.cs = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed then random sequence ----------------
  initial begin
    int     n, lat;
    block_t rd, abcd;
    abcd[0] = 32'hAAAA_0001; abcd[1] = 32'hBBBB_0002;
    abcd[2] = 32'hCCCC_0003; abcd[3] = 32'hDDDD_0004;

    #1;
    do_reset(n);
    check("init_cycles", 32'(n), 32'd256);

    do_req(1'b0, blk_addr(8'h55, 7), rand_block(), 1'b0, lat, rd);
    check("rd0_latency", 32'(lat), 32'd5);
    check("rd0_data", rd, 128'd0);

    do_req(1'b1, blk_addr(8'h12, 0), abcd, 1'b0, lat, rd);
    check("wr12_latency", 32'(lat), 32'd5);
    check("wr12_data", rd, 128'd0);
    do_req(1'b0, blk_addr(8'h12, 3), '0, 1'b0, lat, rd);
    check("rd12_latency", 32'(lat), 32'd5);
    check("rd12_data", rd, abcd);

    do_req(1'b0, blk_addr(8'h12 + 256, 11), '0, 1'b0, lat, rd);
    check("alias_data", rd, abcd);

    do_abort(1'b1, blk_addr(8'h12, 0), rand_block(), 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_ack", mem_res.ack, 1'b0);
    end
    do_req(1'b0, blk_addr(8'h12, 0), '0, 1'b0, lat, rd);
    check("abort_old_data", rd, abcd);

    // Reset while the ack is up must clear ack and data at once.
    do_req(1'b0, blk_addr(8'h12, 0), '0, 1'b0, lat, rd);
    #1;
    rst = 1'b1;
    #1;
    check("rst_resp_ack", mem_res.ack, 1'b0);
    check("rst_resp_data", mem_res.data, 128'd0);
    do_reset(n);
    check("reinit_cycles", 32'(n), 32'd256);

    // Reset in the WAIT of a write: nothing committed.
    do_req(1'b1, blk_addr(8'h34, 0), abcd, 1'b0, lat, rd);
    do_abort(1'b1, blk_addr(8'h34, 0), ~abcd, 2);
    req.cs = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rst_wait_ack", mem_res.ack, 1'b0);
    check("rst_wait_data", mem_res.data, 128'd0);
    check("rst_wait_init_done", init_done, 1'b0);
    do_reset(n);
    check("reinit2_cycles", 32'(n), 32'd256);
    do_req(1'b0, blk_addr(8'h34, 0), '0, 1'b0, lat, rd);
    check("rst_wait_rd_zero", rd, 128'd0);

    for (int t = 0; t < 150; t++) begin
      int     blk;
      logic   rw;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      blk = int'($urandom_range(0, 7)) + 256 * int'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        do_abort(rw, blk_addr(blk, int'($urandom_range(0, 15))), rand_block(),
                 int'($urandom_range(0, 3)));
      end else begin
        do_req(rw, blk_addr(blk, int'($urandom_range(0, 15))), rand_block(),
               ($urandom_range(0, 3) == 0), lat, rd);
        check("rand_latency", 32'(lat), 32'((rw ? WL : RL) + 1));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Block-granular main-memory model/controller on the responder side of the cache's memory_request_t / memory_response_t interface.
- Accepts one block read or block write per transaction and applies a configurable access latency.
- Returns a single-cycle ack with read data.
- Sits below cache; used as system backing store and as the cache's verification partner.

Parameters:
- MEM_BLOCKS, 256, number of stored blocks; power of 2.
- READ_LATENCY, 4, cycles from request acceptance to ack for reads; >= 1.
- WRITE_LATENCY, 4, cycles from request acceptance to ack for writes; >= 1.
- BLK_IDX_W, $clog2(MEM_BLOCKS), block index width (derived).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- mem_req  input  memory_request_t  cs, rw (1 = write), addr, data[BLOCK_SIZE] from cache.
- mem_res  output  memory_response_t  ack, data[BLOCK_SIZE] to cache.
- init_done  output  1  high once post-reset clear completes.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: state=INIT, init counter=0, ack=0, all mem_res.data words=0, init_done=0, latched request cleared.
- Block index: addr[LINE_MSB+BLK_IDX_W-? ...] is taken as the low BLK_IDX_W bits of addr >> OFFSET_WIDTH. Offset bits are ignored. Upper bits alias modulo MEM_BLOCKS.
- State INIT:
  - Writes an all-zero block at index init counter each cycle and increments the counter.
  - After index MEM_BLOCKS-1 is written, go to IDLE and set init_done=1 (registered).
  - cs is ignored during INIT. A request held across INIT is accepted in the first IDLE cycle.
- State IDLE:
  - If cs=1, latch rw, index, and data. Load latency counter with (rw ? WRITE_LATENCY : READ_LATENCY) - 1. Go to WAIT.
  - Otherwise stay in IDLE.
- State WAIT:
  - If cs drops to 0: abort. Return to IDLE with no array write and no ack.
  - Else, if counter != 0, decrement the counter.
  - Else (counter == 0), go to RESPOND:
    - Write: latched block is written to the array on this edge.
    - Read: array block is registered into mem_res.data on this edge.
- State RESPOND:
  - ack=1 for exactly one cycle.
  - mem_res.data is valid only for reads; it is all zeros for writes.
  - Next state is always IDLE. The cache deasserts cs combinationally on ack, so cs is ignored in RESPOND.
- Back-to-back requests:
  - A new request can be accepted in the cycle after RESPOND, e.g. write-back followed by allocate.
  - Total read latency from the first cs-sampled cycle to ack is READ_LATENCY+1 cycles. Writes likewise use WRITE_LATENCY+1.
- Read-after-write to the same block returns the newly written data, because the write commits before its ack.
- ack and mem_res.data are registered outputs (no combinational path from mem_req). Outside RESPOND: ack=0, data=0.
- Request fields are sampled only in IDLE. Changes to addr, data, or rw during WAIT have no effect.
- Reset mid-transaction: the transaction is discarded, no ack is issued, and INIT reruns. A write that has not reached RESPOND is not committed.

Decomposition:
- cache_parameters package: resp_state_t enum (INIT, IDLE, WAIT, RESPOND), block_t (BLOCK_SIZE x WORD_WIDTH), and a block-index extraction function.
- Reuse the existing memory_request_t / memory_response_t typedefs unchanged.
- One natural sub-module: mem_block_array (single-port MEM_BLOCKS x block_t storage with synchronous write and registered read), so it can be swapped for a vendor RAM later.

Test Plan (BLOCK_SIZE=4, WORD_WIDTH=32, READ_LATENCY=WRITE_LATENCY=4, MEM_BLOCKS=256):
1. Reset, then hold cs=0.
   -> init_done rises exactly 256 cycles after rst deasserts; ack stays 0 throughout.
2. Read any address after init.
   -> ack pulses one cycle, 5 cycles after cs is first sampled; data = {0,0,0,0}.
3. Write addr block 0x12 with data {A,B,C,D}, then read addr block 0x12 the cycle after the write ack.
   -> write ack at cycle 5; read ack 5 cycles later with data {A,B,C,D}.
4. Write block 0x12, then read block 0x12+256 (alias).
   -> read returns the same data as block 0x12; the offset bits of addr have no effect.
5. Assert cs, then drop cs in the 2nd WAIT cycle.
   -> no ack; a later read of the same block shows the old contents.
6. Assert rst during WAIT of a write.
   -> ack=0 and data=0 immediately; INIT reruns; the subsequent read of that block returns zeros.
